// File: rtl/frame_swap_controller.sv
// Double-buffer swap controller: the processor draws into the back buffer;
// on vblank after the processor reports a finished frame, the back buffer is
// copied word-by-word into the front buffer. The processor is then
// acknowledged with a 4-phase swap/done handshake.
module frame_swap_controller #(
  parameter  int NUMBER_COLORS = 9,
  parameter  int PIXELS        = 76800,
  localparam int CW            = $clog2(NUMBER_COLORS) + 1,
  localparam int AW            = $clog2(PIXELS)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          enable,
  input  logic          trigger,
  input  logic          done,
  input  logic          proc_we,
  input  logic [AW-1:0] proc_waddr,
  input  logic [CW-1:0] proc_din,
  output logic          swap,
  output logic          busy,
  output logic          bb_we,
  output logic [AW-1:0] bb_waddr,
  output logic [CW-1:0] bb_din,
  output logic [AW-1:0] bb_raddr,
  input  logic [CW-1:0] bb_rdata,
  output logic          fb_we,
  output logic [AW-1:0] fb_waddr,
  output logic [CW-1:0] fb_din,
  output logic          select,
  output logic [7:0]    frame_count
);

  typedef enum logic [1:0] {DRAW, ARMED, COPY, ACK} state_t;

  localparam logic [AW:0]   PIX  = (AW+1)'(PIXELS);
  localparam logic [AW-1:0] LAST = AW'(PIXELS - 1);

  state_t        state, nxt;
  logic          trig_q;
  logic          fe;
  logic          drain;   // last read issued; one cycle left to write it out
  logic [AW-1:0] counter;

  assign fe = trig_q & ~trigger;

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= DRAW;
    else         state <= nxt;
  end

  // Next-state logic; in ARMED a withdrawn enable/done wins over vblank
  always_comb begin
    nxt = state;
    case (state)
      DRAW:    if (done && enable)     nxt = ARMED;
      ARMED:   if (!enable || !done)   nxt = DRAW;
               else if (fe)            nxt = COPY;
      COPY:    if (drain)              nxt = ACK;
      ACK:     if (!done)              nxt = DRAW;
      default:                         nxt = DRAW;
    endcase
  end

  // Outputs decoded from state; processor writes pass straight through in DRAW
  always_comb begin
    bb_we    = (state == DRAW) & proc_we & ({1'b0, proc_waddr} < PIX);
    bb_waddr = proc_waddr;
    bb_din   = proc_din;
    busy     = (state != DRAW);
    select   = (state == COPY);
    swap     = (state == ACK);
  end

  // Copy datapath: counter stalls at the last address while the drain write
  // completes, so no out-of-range address ever reaches either buffer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      trig_q      <= 1'b0;
      counter     <= '0;
      drain       <= 1'b0;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      frame_count <= '0;
    end else begin
      trig_q <= trigger;
      if (state == ARMED && nxt == COPY) begin
        counter <= '0;
        drain   <= 1'b0;
      end else if (state == COPY && !drain) begin
        if (counter == LAST) drain   <= 1'b1;
        else                 counter <= counter + 1'b1;
      end
      fb_we    <= (state == COPY) && !drain;
      fb_waddr <= counter;
      if (state == COPY && drain) frame_count <= frame_count + 8'd1;
    end
  end

  assign bb_raddr = counter;
  assign fb_din   = fb_we ? bb_rdata : '0;

endmodule

// File: tb/tb_frame_swap_controller.sv
// Directed bench for frame_swap_controller with a copy scoreboard.
module tb_frame_swap_controller;
  localparam int PIX = 16;
  localparam int CW  = 5;
  localparam int AW  = 4;
  localparam int AW2 = 5;   // second instance, PIXELS=20, for out-of-range writes

  typedef struct { logic [AW-1:0] addr; logic [CW-1:0] din; } exp_t;

  logic          clk = 1'b0;
  logic          resetn, enable, trigger, done, proc_we;
  logic [AW-1:0] proc_waddr;
  logic [CW-1:0] proc_din, bb_rdata, bb_din, fb_din;
  logic          swap, busy, bb_we, fb_we, select;
  logic [AW-1:0] bb_waddr, bb_raddr, fb_waddr;
  logic [7:0]    frame_count;
  logic [CW-1:0] mem [PIX];

  logic           we2;
  logic [AW2-1:0] waddr2, bb_waddr2, bb_raddr2, fb_waddr2;
  logic [CW-1:0]  bb_din2, fb_din2;
  logic           swap2, busy2, bb_we2, fb_we2, select2;
  logic [7:0]     fc2;

  exp_t q[$];
  int   passed = 0, total = 0;

  always #5 clk = ~clk;

  // Back-buffer RAM model: one-cycle read latency
  always @(posedge clk) bb_rdata <= mem[bb_raddr];

  frame_swap_controller #(.NUMBER_COLORS(9), .PIXELS(PIX)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .trigger(trigger),
    .done(done), .proc_we(proc_we), .proc_waddr(proc_waddr), .proc_din(proc_din),
    .swap(swap), .busy(busy), .bb_we(bb_we), .bb_waddr(bb_waddr), .bb_din(bb_din),
    .bb_raddr(bb_raddr), .bb_rdata(bb_rdata), .fb_we(fb_we), .fb_waddr(fb_waddr),
    .fb_din(fb_din), .select(select), .frame_count(frame_count));

  frame_swap_controller #(.NUMBER_COLORS(9), .PIXELS(20)) u_oor (
    .CLOCK_50(clk), .resetn(resetn), .enable(1'b0), .trigger(1'b0),
    .done(1'b0), .proc_we(we2), .proc_waddr(waddr2), .proc_din(5'd7),
    .swap(swap2), .busy(busy2), .bb_we(bb_we2), .bb_waddr(bb_waddr2), .bb_din(bb_din2),
    .bb_raddr(bb_raddr2), .bb_rdata(5'd0), .fb_we(fb_we2), .fb_waddr(fb_waddr2),
    .fb_din(fb_din2), .select(select2), .frame_count(fc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Arm, fire vblank, run the copy, handshake back to DRAW
  task automatic do_swap(input bit check, input logic [7:0] exp_fc);
    int   nsel, nwe;
    exp_t e;
    done = 1'b1; enable = 1'b1; trigger = 1'b0;
    tick;
    if (check) chk("armed_busy", busy, 1);
    trigger = 1'b1; tick;
    trigger = 1'b0;
    for (int i = 0; i < PIX; i++) q.push_back('{addr: AW'(i), din: mem[i]});
    tick;
    nsel = 0; nwe = 0;
    for (int k = 0; k < PIX + 1; k++) begin
      if (select) nsel++;
      if (fb_we) begin
        nwe++;
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          if (check) begin
            chk("fb_waddr", fb_waddr, e.addr);
            chk("fb_din", fb_din, e.din);
          end
        end
      end
      tick;
    end
    if (check) begin
      chk("copy_select_cycles", nsel, PIX + 1);
      chk("copy_fb_we_cycles", nwe, PIX);
      chk("sb_empty", q.size(), 0);
      chk("ack_swap", swap, 1);
      chk("ack_select", select, 0);
      chk("ack_fb_we", fb_we, 0);
      chk("frame_count", frame_count, exp_fc);
      for (int i = 0; i < 5; i++) begin
        tick;
        chk("swap_hold", swap, 1);
      end
      chk("frame_count_once", frame_count, exp_fc);
    end
    done = 1'b0; #1;
    tick;
    if (check) begin
      chk("swap_release", swap, 0);
      chk("draw_busy", busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < PIX; i++) mem[i] = CW'((i * 7 + 3) % 32);
    resetn = 1'b0; enable = 1'b0; trigger = 1'b0; done = 1'b0;
    proc_we = 1'b0; proc_waddr = '0; proc_din = '0; we2 = 1'b0; waddr2 = '0;
    tick; tick;
    chk("rst_swap", swap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_select", select, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_frame_count", frame_count, 0);
    resetn = 1'b1; tick;

    // Pass-through writes in DRAW
    proc_we = 1'b1; proc_waddr = 4'd3; proc_din = 5'd5; #1;
    chk("draw_bb_we", bb_we, 1);
    chk("draw_bb_waddr", bb_waddr, 3);
    chk("draw_bb_din", bb_din, 5);
    we2 = 1'b1; waddr2 = 5'd20; #1;
    chk("oor_bb_we_20", bb_we2, 0);
    waddr2 = 5'd19; #1;
    chk("oor_bb_we_19", bb_we2, 1);
    we2 = 1'b0; proc_we = 1'b0;
    tick;

    // Vblank in DRAW is ignored
    trigger = 1'b1; tick; trigger = 1'b0; tick;
    chk("draw_fe_select", select, 0);
    tick;
    chk("draw_fe_fb_we", fb_we, 0);
    chk("draw_fe_busy", busy, 0);

    // Processor writes dropped while ARMED; done falling returns to DRAW
    done = 1'b1; enable = 1'b1; tick;
    proc_we = 1'b1; proc_waddr = 4'd2; #1;
    chk("armed_bb_we", bb_we, 0);
    chk("armed_busy", busy, 1);
    proc_we = 1'b0; done = 1'b0; tick;
    chk("armed_done_drop", busy, 0);
    // enable withdrawn while ARMED
    done = 1'b1; tick; enable = 1'b0; tick;
    chk("armed_enable_drop", busy, 0);
    done = 1'b0; tick;

    do_swap(1'b1, 8'd1);

    // Reset mid-copy at cycle 7
    done = 1'b1; enable = 1'b1; tick;
    trigger = 1'b1; tick; trigger = 1'b0; tick;
    repeat (7) tick;
    chk("pre_rst_fb_we", fb_we, 1);
    resetn = 1'b0; #1;
    chk("mid_rst_fb_we", fb_we, 0);
    chk("mid_rst_select", select, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fb_waddr", fb_waddr, 0);
    chk("mid_rst_bb_raddr", bb_raddr, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    done = 1'b0; enable = 1'b0;
    tick; resetn = 1'b1; q.delete();
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_fb_we", fb_we, 0);
    end

    do_swap(1'b1, 8'd1);

    // Frame counter wrap
    for (int n = 0; n < 255; n++) do_swap(1'b0, 8'd0);
    chk("frame_count_wrap", frame_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
